// File: rtl/pool_readout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pool_readout_ctrl
//  Purpose  : Reads the conv/max-pool result memory after the engine finishes.
//             Each word is binarised against max*5/8 and the resulting
//             black/white pixel is written into the VGA frame buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module pool_readout_ctrl #(
  parameter int DEPTH  = 6045,
  parameter int AW     = 13,
  parameter int DW     = 20,
  parameter int PW     = 12,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          conv_done_i,
  input  logic [DW-1:0] max_val_i,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_data_i,
  output logic          fb_we_o,
  output logic [AW-1:0] fb_addr_o,
  output logic [PW-1:0] fb_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW:0]   black_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CONV = 3'd1,
    S_LATCH_THR = 3'd2,
    S_READ      = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          state_q;
  logic            rd_en_q;
  logic [AW-1:0]   rd_addr_q;
  logic            busy_q;
  logic            done_q;
  logic [DW-1:0]   thr_q;
  logic [2:0]      drain_q;
  logic [AW:0]     black_cnt_q;
  logic [AW:0]     black_cnt_d;
  logic [RD_LAT-1:0] vld_q;
  logic [AW-1:0]   addr_q [RD_LAT];

  logic [DW-1:0]   thr_d;
  logic            abort_act;
  logic            wr_black;

  // Threshold is max*5/8 built from two truncating shifts.
  assign thr_d     = (max_val_i >> 1) + (max_val_i >> 3);
  // Abort only matters once a pass has been requested.
  assign abort_act = abort_i && (state_q != S_IDLE);

  // Write port comes straight off the last pipeline stage and the memory data.
  assign fb_we_o   = vld_q[RD_LAT-1];
  assign fb_addr_o = addr_q[RD_LAT-1];
  assign wr_black  = fb_we_o && (rd_data_i > thr_q);
  assign fb_data_o = (fb_we_o && !wr_black) ? {PW{1'b1}} : {PW{1'b0}};

  // Read enable is cut in the abort cycle itself so no further reads issue.
  assign rd_en_o     = rd_en_q && !abort_i;
  assign rd_addr_o   = rd_addr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign black_cnt_o = black_cnt_q;

  // Readout sequencer; all handshake and read-port outputs are registered here.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      thr_q     <= '0;
      drain_q   <= '0;
    end else if (abort_act) begin
      state_q <= S_IDLE;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_WAIT_CONV;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT_CONV: begin
          if (conv_done_i) state_q <= S_LATCH_THR;
        end
        S_LATCH_THR: begin
          thr_q     <= thr_d;
          rd_en_q   <= 1'b1;
          rd_addr_q <= '0;
          state_q   <= S_READ;
        end
        S_READ: begin
          if (rd_addr_q == LAST_ADDR) begin
            rd_en_q <= 1'b0;
            drain_q <= 3'(RD_LAT - 1);
            state_q <= S_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          // Last word's write happens in the final drain cycle.
          if (drain_q == 3'd0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            drain_q <= drain_q - 3'd1;
          end
        end
        S_DONE: begin
          if (start_i) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT_CONV;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Valid/address delay line that tracks the memory read latency.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else if (abort_act) begin
      vld_q <= '0;
    end else begin
      vld_q[0]  <= rd_en_q;
      addr_q[0] <= rd_addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  // Black pixel count: cleared when a pass latches its threshold, kept on abort.
  always_comb begin
    black_cnt_d = black_cnt_q;
    if (state_q == S_LATCH_THR && !abort_i) begin
      black_cnt_d = '0;
    end else if (wr_black) begin
      black_cnt_d = black_cnt_q + (AW+1)'(1);
    end
  end

  // Black pixel count register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) black_cnt_q <= '0;
    else           black_cnt_q <= black_cnt_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_pool_readout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pool_readout_ctrl
//  Purpose  : Directed bench for pool_readout_ctrl. Three instances with
//             read latencies 1, 2 and 3 share the control inputs; each has
//             its own latency-matched model of the result memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pool_readout_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 13;
  localparam int DW    = 20;
  localparam int PW    = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          conv_done;
  logic [DW-1:0] max_val;
  logic [DW-1:0] mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic          rd_en1, rd_en2, rd_en3;
  logic [AW-1:0] rd_addr1, rd_addr2, rd_addr3;
  logic [DW-1:0] rd_data1, rd_data2, rd_data3;
  logic          fb_we1, fb_we2, fb_we3;
  logic [AW-1:0] fb_addr1, fb_addr2, fb_addr3;
  logic [PW-1:0] fb_data1, fb_data2, fb_data3;
  logic          busy1, busy2, busy3;
  logic          done1, done2, done3;
  logic [AW:0]   bcnt1, bcnt2, bcnt3;

  // Memory models: address delayed RD_LAT cycles, data read combinationally.
  logic [2:0] a1_q = '0;
  logic [2:0] a2_q [0:1] = '{3'd0, 3'd0};
  logic [2:0] a3_q [0:2] = '{3'd0, 3'd0, 3'd0};

  always @(posedge clk) a1_q <= rd_addr1[2:0];
  always @(posedge clk) begin a2_q[0] <= rd_addr2[2:0]; a2_q[1] <= a2_q[0]; end
  always @(posedge clk) begin a3_q[0] <= rd_addr3[2:0]; a3_q[1] <= a3_q[0]; a3_q[2] <= a3_q[1]; end

  assign rd_data1 = mem[a1_q];
  assign rd_data2 = mem[a2_q[1]];
  assign rd_data3 = mem[a3_q[2]];

  pool_readout_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW), .RD_LAT(1)) u_dut1 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .abort_i(abort),
    .conv_done_i(conv_done), .max_val_i(max_val),
    .rd_en_o(rd_en1), .rd_addr_o(rd_addr1), .rd_data_i(rd_data1),
    .fb_we_o(fb_we1), .fb_addr_o(fb_addr1), .fb_data_o(fb_data1),
    .busy_o(busy1), .done_o(done1), .black_cnt_o(bcnt1)
  );

  pool_readout_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW), .RD_LAT(2)) u_dut2 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .abort_i(abort),
    .conv_done_i(conv_done), .max_val_i(max_val),
    .rd_en_o(rd_en2), .rd_addr_o(rd_addr2), .rd_data_i(rd_data2),
    .fb_we_o(fb_we2), .fb_addr_o(fb_addr2), .fb_data_o(fb_data2),
    .busy_o(busy2), .done_o(done2), .black_cnt_o(bcnt2)
  );

  pool_readout_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW), .RD_LAT(3)) u_dut3 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .abort_i(abort),
    .conv_done_i(conv_done), .max_val_i(max_val),
    .rd_en_o(rd_en3), .rd_addr_o(rd_addr3), .rd_data_i(rd_data3),
    .fb_we_o(fb_we3), .fb_addr_o(fb_addr3), .fb_data_o(fb_data3),
    .busy_o(busy3), .done_o(done3), .black_cnt_o(bcnt3)
  );

  // One-cycle start pulse; returns one time unit after the sampling edge.
  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Runs one pass and collects write statistics of the RD_LAT=1 instance.
  task automatic run_pass1(output int nw, output int nwhite, output int nblack, output bit order_ok);
    nw = 0; nwhite = 0; nblack = 0; order_ok = 1'b1;
    pulse_start();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fb_we1) begin
        if (fb_addr1 !== 13'(nw)) order_ok = 1'b0;
        if (fb_data1 === 12'hFFF) nwhite++;
        if (fb_data1 === 12'h000) nblack++;
        nw++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; conv_done = 1'b0; max_val = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    idle_cycles(3);
    @(negedge clk);
    checks++;
    if ({rd_en1, rd_addr1, fb_we1, fb_addr1, fb_data1, busy1, done1, bcnt1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_lat1 got rd_en=%0b rd_addr=%0d fb_we=%0b fb_addr=%0d fb_data=%0h busy=%0b done=%0b bcnt=%0d want all 0",
               rd_en1, rd_addr1, fb_we1, fb_addr1, fb_data1, busy1, done1, bcnt1);
    end
    checks++;
    if ({busy2, done2, fb_we2, busy3, done3, fb_we3} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs_lat23 got %b want 000000", {busy2, done2, fb_we2, busy3, done3, fb_we3});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  // RD_LAT=1, thr=50, data=addr*10: six white (0..50), two black (60,70).
  task automatic test_basic;
    int nw, first_rd, first_wr, done_at;
    bit busy_c0;
    logic [PW-1:0] exp;
    conv_done = 1'b1; max_val = 20'd80;
    for (int i = 0; i < DEPTH; i++) mem[i] = 20'(i * 10);
    pulse_start();
    nw = 0; first_rd = -1; first_wr = -1; done_at = -1; busy_c0 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) busy_c0 = busy1;
      if (rd_en1 && first_rd < 0) first_rd = c;
      if (fb_we1) begin
        if (first_wr < 0) first_wr = c;
        exp = (nw >= 6) ? 12'h000 : 12'hFFF;
        checks++;
        if (fb_addr1 !== 13'(nw) || fb_data1 !== exp) begin
          errors++;
          $display("FAIL basic_write%0d got addr=%0d data=%0h want addr=%0d data=%0h", nw, fb_addr1, fb_data1, nw, exp);
        end
        nw++;
      end
      if (done1 && done_at < 0) done_at = c;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_c0 !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start got %0b want 1", busy_c0); end
    checks++;
    if (nw != 8) begin errors++; $display("FAIL basic_write_count got %0d want 8", nw); end
    checks++;
    if (bcnt1 !== 14'd2) begin errors++; $display("FAIL basic_black_cnt got %0d want 2", bcnt1); end
    checks++;
    if (first_rd != 2 || first_wr != 3) begin
      errors++; $display("FAIL basic_latency got rd=%0d wr=%0d want rd=2 wr=3", first_rd, first_wr);
    end
    // Cycle 11 after the start edge = 12 clocks including it = DEPTH+RD_LAT+3.
    checks++;
    if (done_at != 11) begin errors++; $display("FAIL basic_done_time got %0d want 11", done_at); end
  endtask

  // RD_LAT=3: write lags read by 3, three drain cycles with rd_en low.
  task automatic test_rd_lat3;
    int nw, first_rd, first_wr, done_at, drain;
    bit contig;
    pulse_start();
    nw = 0; first_rd = -1; first_wr = -1; done_at = -1; drain = 0; contig = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rd_en3 && first_rd < 0) first_rd = c;
      if (first_rd >= 0 && busy3 && !rd_en3) drain++;
      if (fb_we3) begin
        if (first_wr < 0) first_wr = c;
        if (fb_addr3 !== 13'(nw)) contig = 1'b0;
        nw++;
      end
      if (done3 && done_at < 0) done_at = c;
      @(posedge clk); #1;
    end
    checks++;
    if (first_wr - first_rd != 3) begin
      errors++; $display("FAIL lat3_first_write got %0d want 3", first_wr - first_rd);
    end
    checks++;
    if (nw != 8 || !contig) begin
      errors++; $display("FAIL lat3_writes got count=%0d contiguous=%0b want count=8 contiguous=1", nw, contig);
    end
    checks++;
    if (drain != 3) begin errors++; $display("FAIL lat3_drain_cycles got %0d want 3", drain); end
    checks++;
    if (done_at != 13) begin errors++; $display("FAIL lat3_done_time got %0d want 13", done_at); end
    checks++;
    if (bcnt3 !== 14'd2) begin errors++; $display("FAIL lat3_black_cnt got %0d want 2", bcnt3); end
  endtask

  // Start with conv_done low: wait with busy high, no reads, then go.
  task automatic test_wait_conv;
    int bad, rise;
    conv_done = 1'b0;
    pulse_start();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd_en1 !== 1'b0 || busy1 !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wait_conv_hold got %0d bad cycles want 0", bad); end
    conv_done = 1'b1;
    rise = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd_en1 && rise < 0) rise = c;
      @(posedge clk); #1;
    end
    checks++;
    if (rise != 2) begin errors++; $display("FAIL wait_conv_start_delay got %0d want 2", rise); end
    idle_cycles(20);
  endtask

  // Abort on the 4th READ cycle of the RD_LAT=2 instance, then a clean pass.
  task automatic test_abort;
    int nw, late;
    bit order;
    conv_done = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 20'hFFFFF;
    pulse_start();
    nw = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) abort = 1'b1;
      @(negedge clk);
      if (fb_we2) nw++;
      @(posedge clk); #1;
    end
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_en2, busy2, done2} !== 3'b000) begin
      errors++; $display("FAIL abort_state got rd_en/busy/done=%b want 000", {rd_en2, busy2, done2});
    end
    late = 0;
    for (int c = 0; c < 10; c++) begin
      if (fb_we2 || busy2) late++;
      @(negedge clk);
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL abort_no_late_writes got %0d want 0", late); end
    checks++;
    if (nw != 2 || bcnt2 !== 14'd2) begin
      errors++; $display("FAIL abort_partial got writes=%0d bcnt=%0d want writes=2 bcnt=2", nw, bcnt2);
    end
    @(posedge clk); #1;
    // Second pass must complete normally.
    pulse_start();
    nw = 0; order = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fb_we2) begin
        if (fb_addr2 !== 13'(nw)) order = 1'b0;
        nw++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nw != 8 || !order || bcnt2 !== 14'd8 || done2 !== 1'b1) begin
      errors++; $display("FAIL abort_second_pass got writes=%0d order=%0b bcnt=%0d done=%0b want 8 1 8 1", nw, order, bcnt2, done2);
    end
    // Abort together with start in DONE: abort wins.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy2, done2} !== 2'b00) begin
      errors++; $display("FAIL abort_beats_start got busy/done=%b want 00", {busy2, done2});
    end
    @(posedge clk); #1;
    // Abort in IDLE is ignored; a following start is accepted.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    pulse_start();
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL abort_idle_noeffect got busy=%0b want 1", busy2); end
    @(posedge clk); #1;
    idle_cycles(25);
  endtask

  // Asynchronous reset between clock edges while reading.
  task automatic test_async_reset;
    int bad;
    for (int i = 0; i < DEPTH; i++) mem[i] = 20'(i * 10);
    pulse_start();
    idle_cycles(4);
    @(negedge clk);
    checks++;
    if (rd_en1 !== 1'b1) begin errors++; $display("FAIL areset_precond got rd_en=%0b want 1", rd_en1); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_en1, rd_addr1, fb_we1, fb_addr1, fb_data1, busy1, done1, bcnt1} !== '0) begin
      errors++;
      $display("FAIL areset_outputs got rd_en=%0b rd_addr=%0d fb_we=%0b fb_addr=%0d fb_data=%0h busy=%0b done=%0b bcnt=%0d want all 0",
               rd_en1, rd_addr1, fb_we1, fb_addr1, fb_data1, busy1, done1, bcnt1);
    end
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy1 || rd_en1 || done1 || fb_we1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL areset_stays_idle got %0d bad cycles want 0", bad); end
    @(posedge clk); #1;
  endtask

  // Threshold extremes: thr=0 with zero data, and thr=0x9FFFE with full-scale data.
  task automatic test_thresholds;
    int nw, nwhite, nblack;
    bit order;
    max_val = 20'd0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 20'd0;
    run_pass1(nw, nwhite, nblack, order);
    checks++;
    if (nw != 8 || nwhite != 8 || !order || bcnt1 !== 14'd0) begin
      errors++; $display("FAIL thr_zero got writes=%0d white=%0d order=%0b bcnt=%0d want 8 8 1 0", nw, nwhite, order, bcnt1);
    end
    max_val = 20'hFFFFF;
    for (int i = 0; i < DEPTH; i++) mem[i] = 20'hFFFFF;
    run_pass1(nw, nwhite, nblack, order);
    checks++;
    if (nw != 8 || nblack != 8 || !order || bcnt1 !== 14'd8) begin
      errors++; $display("FAIL thr_full got writes=%0d black=%0d order=%0b bcnt=%0d want 8 8 1 8", nw, nblack, order, bcnt1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rd_lat3();
    test_wait_conv();
    test_abort();
    test_async_reset();
    test_thresholds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
